// File: rtl/types_pkg.sv
// -----------------------------------------------------------------------------
// types_pkg -- shared front-end types.
//   decode_data : one decoded instruction (pc, register indices, immediate,
//                 ALU operation class, raw opcode, functional unit).
//   fu_t        : functional-unit encoding.
//   DECODE_Q_DEPTH : default depth of the decode queue.
// Also holds the RV32 opcode and ALUOp constants used by decode.
// -----------------------------------------------------------------------------
package types_pkg;

  localparam int DECODE_Q_DEPTH = 4;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_MEM = 2'd1,
    FU_BR  = 2'd2
  } fu_t;

  // RV32I major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // ALU operation class
  localparam logic [2:0] ALUOP_R     = 3'b000;
  localparam logic [2:0] ALUOP_LOAD  = 3'b001;
  localparam logic [2:0] ALUOP_STORE = 3'b010;
  localparam logic [2:0] ALUOP_IMM   = 3'b011;
  localparam logic [2:0] ALUOP_LUI   = 3'b100;
  localparam logic [2:0] ALUOP_AUIPC = 3'b101;
  localparam logic [2:0] ALUOP_BR    = 3'b110;
  localparam logic [2:0] ALUOP_JUMP  = 3'b111;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  ALUOp;
    logic [6:0]  Opcode;
    fu_t         fu;
  } decode_data;

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/decode_queue_if.sv
// -----------------------------------------------------------------------------
// decode_queue_if -- handshake bundle between fetch, decode_queue and rename.
//   instr/pc_in/valid_in/ready_in : upstream valid/ready enqueue side
//   flush                         : synchronous discard of all entries
//   valid_out/ready_out/data_out  : downstream valid/ready dequeue side
//   count                         : queue occupancy
// modport slave  : the queue
// modport master : the environment driving it
// -----------------------------------------------------------------------------
interface decode_queue_if #(
  parameter int DEPTH = types_pkg::DECODE_Q_DEPTH
);
  import types_pkg::*;

  logic [31:0]                  instr;
  logic [31:0]                  pc_in;
  logic                         valid_in;
  logic                         ready_in;
  logic                         flush;
  logic                         valid_out;
  logic                         ready_out;
  decode_data                   data_out;
  logic [$clog2(DEPTH+1)-1:0]   count;

  modport slave (
    input  instr, pc_in, valid_in, flush, ready_out,
    output ready_in, valid_out, data_out, count
  );

  modport master (
    output instr, pc_in, valid_in, flush, ready_out,
    input  ready_in, valid_out, data_out, count
  );

endinterface

// File: rtl/decode_queue_decode.sv
// -----------------------------------------------------------------------------
// decode -- combinational RV32 decode stage.
//   instr, pc_in   : raw instruction and its PC
//   valid_in       : passed straight to valid_out
//   ready_out      : passed straight to ready_in
//   data_out       : decoded fields (decode_data)
// Immediates are fully sign-extended per instruction format; R-type and
// unknown opcodes give imm 0.
// -----------------------------------------------------------------------------
module decode
  import types_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc_in,
  input  logic        valid_in,
  output logic        ready_in,
  output logic        valid_out,
  input  logic        ready_out,
  output decode_data  data_out
);

  assign valid_out = valid_in;
  assign ready_in  = ready_out;

  always_comb begin
    data_out        = '0;
    data_out.pc     = pc_in;
    data_out.rs1    = instr[19:15];
    data_out.rs2    = instr[24:20];
    data_out.rd     = instr[11:7];
    data_out.Opcode = instr[6:0];
    data_out.ALUOp  = ALUOP_R;
    data_out.fu     = FU_ALU;
    data_out.imm    = '0;
    case (instr[6:0])
      OPC_OP: data_out.ALUOp = ALUOP_R;
      OPC_OPIMM: begin
        data_out.ALUOp = ALUOP_IMM;
        data_out.imm   = sext12(instr[31:20]);
      end
      OPC_LOAD: begin
        data_out.ALUOp = ALUOP_LOAD;
        data_out.fu    = FU_MEM;
        data_out.imm   = sext12(instr[31:20]);
      end
      OPC_STORE: begin
        data_out.ALUOp = ALUOP_STORE;
        data_out.fu    = FU_MEM;
        data_out.imm   = sext12({instr[31:25], instr[11:7]});
      end
      OPC_LUI: begin
        data_out.ALUOp = ALUOP_LUI;
        data_out.imm   = {instr[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        data_out.ALUOp = ALUOP_AUIPC;
        data_out.imm   = {instr[31:12], 12'b0};
      end
      OPC_BRANCH: begin
        data_out.ALUOp = ALUOP_BR;
        data_out.fu    = FU_BR;
        data_out.imm   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                          instr[11:8], 1'b0};
      end
      OPC_JAL: begin
        data_out.ALUOp = ALUOP_JUMP;
        data_out.fu    = FU_BR;
        data_out.imm   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                          instr[30:21], 1'b0};
      end
      OPC_JALR: begin
        data_out.ALUOp = ALUOP_JUMP;
        data_out.fu    = FU_BR;
        data_out.imm   = sext12(instr[31:20]);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/decode_queue.sv
// -----------------------------------------------------------------------------
// decode_queue -- registered decode stage with a DEPTH-entry circular queue.
//   clk    : rising-edge clock
//   reset  : synchronous, active-high
//   bus    : decode_queue_if.slave (enqueue handshake, dequeue handshake,
//            flush, occupancy count)
// Instructions are decoded on the way in and the decode_data result is
// stored; the head entry is presented on data_out.
// Optional feature macro DECODE_QUEUE_BYPASS_EN: when the queue is empty an
// incoming instruction is presented on data_out in the same cycle, and is not
// stored if downstream takes it immediately.
// -----------------------------------------------------------------------------
module decode_queue
  import types_pkg::*;
#(
  parameter int DEPTH = DECODE_Q_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  decode_queue_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  decode_data           mem_q [DEPTH];
  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;

  decode_data           dec;
  logic                 dec_vld, dec_rdy;
  logic                 unused_dec;
  logic                 empty, full, byp, enq, deq;

  decode u_decode (
    .instr     (bus.instr),
    .pc_in     (bus.pc_in),
    .valid_in  (bus.valid_in),
    .ready_in  (dec_rdy),
    .valid_out (dec_vld),
    .ready_out (1'b1),
    .data_out  (dec)
  );

  // decode's own handshake is meaningless here; the queue owns flow control
  assign unused_dec = dec_vld ^ dec_rdy;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  // Depends only on registered state (and reset), never on ready_out, so a
  // full queue refuses even when a dequeue happens in the same cycle.
  assign bus.ready_in = !full && !reset;

`ifdef DECODE_QUEUE_BYPASS_EN
  assign byp = empty && bus.valid_in && !bus.flush;
`else
  assign byp = 1'b0;
`endif

  assign bus.valid_out = !empty || byp;
  assign bus.data_out  = byp ? dec : mem_q[head_q];
  assign bus.count     = count_q;

  // A bypassed entry taken by downstream in the same cycle is never stored.
  assign enq = bus.valid_in && bus.ready_in && !(byp && bus.ready_out);
  assign deq = !empty && bus.ready_out;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) tail_d = tail_q + PTR_W'(1);
      if (deq) head_d = head_q + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is never cleared; it is only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (!reset && !bus.flush && enq) mem_q[tail_q] <= dec;
  end

endmodule

// File: tb/tb_decode_queue.sv
module tb_decode_queue;
  import types_pkg::*;

  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  decode_data mq[$];
  logic [31:0] pcn = 32'h0;

  decode_queue_if #(.DEPTH(DEPTH)) bus ();
  decode_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference decode written from the RV32 format rules with plain arithmetic.
  function automatic decode_data ref_dec(input logic [31:0] w, input logic [31:0] p);
    decode_data d;
    int s;
    s = $signed(w);
    d        = '0;
    d.pc     = p;
    d.rd     = 5'((w >> 7) & 32'h1F);
    d.rs1    = 5'((w >> 15) & 32'h1F);
    d.rs2    = 5'((w >> 20) & 32'h1F);
    d.Opcode = 7'(w & 32'h7F);
    d.ALUOp  = 3'd0;
    d.fu     = FU_ALU;
    d.imm    = 32'h0;
    case (w & 32'h7F)
      32'h33: ;
      32'h13: begin d.ALUOp = 3'd3; d.imm = 32'(s >>> 20); end
      32'h03: begin d.ALUOp = 3'd1; d.fu = FU_MEM; d.imm = 32'(s >>> 20); end
      32'h23: begin
        d.ALUOp = 3'd2; d.fu = FU_MEM;
        d.imm = 32'((s >>> 25) * 32) | ((w >> 7) & 32'h1F);
      end
      32'h37: begin d.ALUOp = 3'd4; d.imm = w & 32'hFFFFF000; end
      32'h17: begin d.ALUOp = 3'd5; d.imm = w & 32'hFFFFF000; end
      32'h63: begin
        d.ALUOp = 3'd6; d.fu = FU_BR;
        d.imm = 32'((s >>> 31) * 4096) | (((w >> 7) & 1) << 11)
              | (((w >> 25) & 32'h3F) << 5) | (((w >> 8) & 32'hF) << 1);
      end
      32'h6F: begin
        d.ALUOp = 3'd7; d.fu = FU_BR;
        d.imm = 32'((s >>> 31) * 1048576) | (((w >> 12) & 32'hFF) << 12)
              | (((w >> 20) & 1) << 11) | (((w >> 21) & 32'h3FF) << 1);
      end
      32'h67: begin d.ALUOp = 3'd7; d.fu = FU_BR; d.imm = 32'(s >>> 20); end
      default: ;
    endcase
    return d;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic fl, input logic vin, input logic rout,
                       input logic [31:0] ins, input logic [31:0] p);
    reset         = rst;
    bus.flush     = fl;
    bus.valid_in  = vin;
    bus.ready_out = rout;
    bus.instr     = ins;
    bus.pc_in     = p;
  endtask

  // Check outputs against the model, then advance one clock and update the model.
  task automatic tick(output logic acc);
    decode_data exp_d;
    logic byp, exp_r, exp_v, full, taken;
    #1;
    byp = 1'b0;
`ifdef DECODE_QUEUE_BYPASS_EN
    byp = (mq.size() == 0) && bus.valid_in && !bus.flush;
`endif
    exp_r = (mq.size() != DEPTH) && !reset;
    exp_v = (mq.size() != 0) || byp;
    chk("ready_in", 128'(bus.ready_in), 128'(exp_r));
    chk("valid_out", 128'(bus.valid_out), 128'(exp_v));
    chk("count", 128'(bus.count), 128'(mq.size()));
    if (exp_v) begin
      exp_d = byp ? ref_dec(bus.instr, bus.pc_in) : mq[0];
      chk("data_out", 128'(bus.data_out), 128'(exp_d));
    end
    acc   = bus.valid_in && exp_r;
    full  = (mq.size() == DEPTH);
    taken = byp && bus.ready_out;
    @(posedge clk);
    if (reset || bus.flush) mq.delete();
    else if (!taken) begin
      if (mq.size() != 0 && bus.ready_out) void'(mq.pop_front());
      if (bus.valid_in && !full) mq.push_back(ref_dec(bus.instr, bus.pc_in));
    end
    #2;
  endtask

  task automatic push(input logic [31:0] ins);
    logic acc;
    drive(1'b0, 1'b0, 1'b1, 1'b0, ins, pcn);
    tick(acc);
    pcn += 4;
  endtask

  task automatic idle(input logic rout, input int n);
    logic acc;
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 1'b0, rout, 32'h0, 32'h0);
      tick(acc);
    end
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [6:0] opcs [10];
    opcs = '{7'h33, 7'h03, 7'h23, 7'h13, 7'h37, 7'h17, 7'h63, 7'h6F, 7'h67, 7'h0B};
    return {25'($urandom), opcs[$urandom_range(0, 9)]};
  endfunction

  initial begin
    logic acc, pend;
    logic [31:0] pi, pp;
    logic [31:0] fill [5];
    logic [31:0] fimm [5];

    // reset
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick(acc);
    tick(acc);
    idle(1'b0, 1);

    // ADDI 0xFFF30293 at pc 0 with ready_out high
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFF30293, 32'h0);
`ifdef DECODE_QUEUE_BYPASS_EN
    #1;
    chk("byp_valid", 128'(bus.valid_out), 128'(1'b1));
    chk("byp_rd", 128'(bus.data_out.rd), 128'(5));
    chk("byp_rs1", 128'(bus.data_out.rs1), 128'(6));
    chk("byp_imm", 128'(bus.data_out.imm), 128'(32'hFFFFFFFF));
    chk("byp_aluop", 128'(bus.data_out.ALUOp), 128'(3'b011));
    tick(acc);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    #1;
    chk("byp_count0", 128'(bus.count), 128'(0));
    tick(acc);
`else
    tick(acc);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    #1;
    chk("addi_valid", 128'(bus.valid_out), 128'(1'b1));
    chk("addi_rd", 128'(bus.data_out.rd), 128'(5));
    chk("addi_rs1", 128'(bus.data_out.rs1), 128'(6));
    chk("addi_imm", 128'(bus.data_out.imm), 128'(32'hFFFFFFFF));
    chk("addi_aluop", 128'(bus.data_out.ALUOp), 128'(3'b011));
    chk("addi_opcode", 128'(bus.data_out.Opcode), 128'(7'b0010011));
    tick(acc);
`endif
    idle(1'b0, 1);

    // fill to full, fifth held, then drain in order
    fill = '{32'hABCDE1B7, 32'h005201B3, 32'hFF042503, 32'h00542423, 32'h00209863};
    fimm = '{32'hABCDE000, 32'h0, 32'hFFFFFFF0, 32'h8, 32'h10};
    for (int i = 0; i < 4; i++) push(fill[i]);
    drive(1'b0, 1'b0, 1'b1, 1'b0, fill[4], pcn);
    #1;
    chk("full_ready_in", 128'(bus.ready_in), 128'(1'b0));
    chk("full_count", 128'(bus.count), 128'(4));
    tick(acc);
    chk("full_held", 128'(acc), 128'(1'b0));
    pend = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b0, pend, 1'b1, fill[4], pcn);
      #1;
      chk("drain_imm", 128'(bus.data_out.imm), 128'(fimm[k]));
      tick(acc);
      if (acc) pend = 1'b0;
    end
    pcn += 4;
    idle(1'b1, 1);

    // steady state at count 2, pointers wrap
    push(rnd_instr());
    push(rnd_instr());
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, rnd_instr(), pcn);
      #1;
      chk("steady_count", 128'(bus.count), 128'(2));
      tick(acc);
      pcn += 4;
    end
    idle(1'b1, 3);

    // flush with a same-cycle JALR
    for (int i = 0; i < 3; i++) push(rnd_instr());
    drive(1'b0, 1'b1, 1'b1, 1'($urandom_range(0, 1)), 32'h00C000E7, pcn);
    tick(acc);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("flush_count", 128'(bus.count), 128'(0));
    chk("flush_valid", 128'(bus.valid_out), 128'(1'b0));
    chk("flush_ready", 128'(bus.ready_in), 128'(1'b1));
    tick(acc);

    // reset mid-stream
    for (int i = 0; i < 3; i++) push(rnd_instr());
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick(acc);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("rst_count", 128'(bus.count), 128'(0));
    chk("rst_valid", 128'(bus.valid_out), 128'(1'b0));
    chk("rst_ready", 128'(bus.ready_in), 128'(1'b1));
    tick(acc);
    push(32'h00209863);
    idle(1'b1, 2);

    // randomized traffic against the model
    pend = 1'b0;
    pi = 32'h0;
    pp = 32'h0;
    for (int c = 0; c < 400; c++) begin
      if (!pend && $urandom_range(0, 3) != 0) begin
        pi = rnd_instr();
        pp = pcn;
        pcn += 4;
        pend = 1'b1;
      end
      drive(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 19) == 0), pend,
            1'($urandom_range(0, 1)), pi, pp);
      tick(acc);
      if (acc) pend = 1'b0;
    end
    idle(1'b1, DEPTH + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_queue.md
# decode_queue

Registered, parametrised successor to the combinational decode stage. Accepts raw instructions and their PCs over a valid/ready handshake and decodes each one through the existing `decode` logic. Decoded `decode_data` entries are held in a DEPTH-entry circular queue, so fetch is decoupled from rename/dispatch. It also supports a synchronous flush for mispredict/exception recovery. The block sits between the fetch/instruction buffer and the rename stage.

## Interface
- `DEPTH`, 4: number of queue entries; power of two, ≥2.
- `CNT_W`, `$clog2(DEPTH+1)`: width of the occupancy count (derived; not overridden).

- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `instr`  in  32  raw instruction word.
- `pc_in`  in  32  PC of `instr`.
- `valid_in`  in  1  upstream holds a valid instruction.
- `ready_in`  out  1  queue can accept this cycle.
- `flush`  in  1  discard all queued entries.
- `valid_out`  out  1  `data_out` holds a valid decoded entry.
- `ready_out`  in  1  downstream accepts `data_out` this cycle.
- `data_out`  out  `decode_data`  decoded head entry (`pc`, `rs1`, `rs2`, `rd`, `imm`, `ALUOp`, `Opcode`, `fu`).
- `count`  out  `CNT_W`  current occupancy.

## Operation
- Enqueue fires when `valid_in && ready_in`: the decoded input is written at `tail`, and `tail` advances modulo DEPTH.
- Dequeue fires when `valid_out && ready_out`: `head` advances modulo DEPTH.
- `ready_in = (count != DEPTH) && !reset`.
  - `ready_in` is a function of registered state only. There is no combinational path from `ready_out`.
  - When the queue is full, an enqueue is refused even if a dequeue fires in the same cycle.
- `valid_out = (count != 0)`, subject to the bypass rule in Configuration. `data_out` equals `mem[head]`.
- Occupancy update:
  - Enqueue only: `count` +1.
  - Dequeue only: `count` −1.
  - Both in the same cycle: `count` unchanged, both pointers advance.
- Pointers are `$clog2(DEPTH)` bits wide and wrap naturally. Full and empty are distinguished by `count`, never by pointer equality.
- Priority order: `reset` > `flush` > enqueue/dequeue.
- `flush`: at the next edge, `head = tail = 0` and `count = 0`.
  - Any same-cycle enqueue is dropped.
  - Any same-cycle dequeue is not counted.
  - `ready_out` during a flush cycle carries no meaning.
- Queue storage is not cleared by reset or flush. It is only read when `count != 0`.
- `data_out` must be bit-identical to what the combinational `decode` produces for the same `instr` and `pc_in`. Examples: ADDI 0xFFF30293 gives imm 0xFFFFFFFF and ALUOp 3'b011; LUI gives ALUOp 3'b100.

## Timing
- Reset values: `valid_out` 0, `ready_in` 0 while `reset` is high and 1 in the first cycle after, `count` 0, `head` 0, `tail` 0, `data_out` don't-care.
- Latency without bypass: an instruction accepted at edge N appears on `data_out` with `valid_out = 1` in the cycle after edge N.
- Throughput: one enqueue and one dequeue per cycle, sustained, when `count` is between 1 and DEPTH−1.
- Once asserted, `valid_out` and `data_out` stay stable until a dequeue or a flush.
- Upstream must hold `instr`, `pc_in` and `valid_in` until `ready_in` is seen high at an edge.
- A flush asserted at edge N gives `valid_out = 0` and `ready_in = 1` after edge N.

## Configuration
- `DECODE_QUEUE_BYPASS_EN` defined: when `count == 0 && valid_in && !flush`, `valid_out = 1` and `data_out` is the combinationally decoded input.
  - If `ready_out` is also high, the entry is consumed in the same cycle and not written; `count` stays 0.
  - Otherwise the entry is enqueued normally.
- Not defined: no bypass; minimum latency is 1 cycle; `valid_out` depends only on `count`.

## Structure
- `decode_data` and the `fu` encoding stay in `types_pkg`. Add `DECODE_Q_DEPTH` (default 4) to `types_pkg` as the top-level default.
- One sub-module: the existing combinational `decode`, instantiated once on the input path. Its `valid_out` and `ready_in` are unused and its `ready_out` is tied to 1.
- The queue storage, pointers and count live in `decode_queue` itself.

## Test plan
- Reset, then ADDI 0xFFF30293 at pc 0x0 with `ready_out = 1` → one cycle later `valid_out = 1`, rd 5, rs1 6, imm 0xFFFFFFFF, ALUOp 011, Opcode 0010011; `count` returns to 0.
- DEPTH=4, `ready_out = 0`, push LUI 0xABCDE1B7, ADD 0x005201B3, LW 0xFF042503, SW 0x00542423 → `ready_in = 0` after the 4th, `count = 4`, a 5th (BNE 0x00209863) is held. Then `ready_out = 1` → outputs in order LUI (imm 0xABCDE000), ADD, LW (imm 0xFFFFFFF0), SW (imm 0x8), then BNE (imm 0x10).
- Queue at `count = 2`, `valid_in` and `ready_out` both high for 6 cycles → `count` stays 2; the pointers wrap past DEPTH with no data corruption.
- `count = 3`, assert `flush` together with `valid_in` carrying JALR 0x00C000E7 → next cycle `count = 0`, `valid_out = 0`; JALR is not enqueued.
- Assert `reset` mid-stream at `count = 3` → after the edge all outputs are at their reset values; the first post-reset push is returned correctly.
- With `DECODE_QUEUE_BYPASS_EN` defined, empty queue, ADDI presented with `ready_out = 1` → `valid_out = 1` in the same cycle with the correct fields, and `count` stays 0.
